// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU memory-stage port, host port with lock, and RAM port.
// slave = arbiter view, master = environment (pipeline/host/RAM) view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              host_lock;
    logic              host_lock_ack;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        output host_gnt, host_rvalid, host_rdata, host_lock_ack,
        output ram_address, ram_data, ram_wren,
        input  ram_q
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        input  host_gnt, host_rvalid, host_rdata, host_lock_ack,
        input  ram_address, ram_data, ram_wren,
        output ram_q
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter between CPU memory stage and host port, with host lock.
// Optional host-starvation bound compiled in with macro DMEM_ARB_FAIRNESS_EN.
module dmem_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     bus
);

    typedef enum logic [0:0] {
        S_SHARED = 1'b0,
        S_LOCK   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rd_valid;
    logic              r_rd_owner_host;
    logic              w_fair_hit;
    logic              w_host_gnt;
    logic              w_cpu_gnt;
    logic [ADDR_W-1:0] w_ram_address;
    logic [DATA_W-1:0] w_ram_data;
    logic              w_ram_wren;

    // Ownership state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_SHARED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock request moves ownership on the following cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SHARED: begin
                if (bus.host_lock) begin
                    w_state_nxt = S_LOCK;
                end else begin
                    w_state_nxt = S_SHARED;
                end
            end
            S_LOCK: begin
                if (!bus.host_lock) begin
                    w_state_nxt = S_SHARED;
                end else begin
                    w_state_nxt = S_LOCK;
                end
            end
            default: w_state_nxt = S_SHARED;
        endcase
    end

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_CPU_BURST);

    logic [7:0] r_burst_cnt;

    // Counts CPU wins while the host waits; saturates so the hit never wraps away
    always_ff @(posedge clk) begin
        if (reset) begin
            r_burst_cnt <= 8'd0;
        end else if (w_host_gnt || !bus.host_req) begin
            r_burst_cnt <= 8'd0;
        end else if (w_cpu_gnt && (r_burst_cnt != 8'hFF)) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
        end else begin
            r_burst_cnt <= r_burst_cnt;
        end
    end

    assign w_fair_hit = (r_burst_cnt >= BURST_LIMIT);
`else
    assign w_fair_hit = 1'b0;
`endif

    // Grant decision; everything is held off while reset is high
    always_comb begin
        w_host_gnt = 1'b0;
        w_cpu_gnt  = 1'b0;
        if (reset) begin
            w_host_gnt = 1'b0;
            w_cpu_gnt  = 1'b0;
        end else if (r_state == S_LOCK) begin
            w_host_gnt = bus.host_req;
            w_cpu_gnt  = 1'b0;
        end else begin
            w_host_gnt = bus.host_req && (!bus.cpu_req || w_fair_hit);
            w_cpu_gnt  = bus.cpu_req && !(bus.host_req && (!bus.cpu_req || w_fair_hit));
        end
    end

    // RAM port steering: idle cycles drive zeros rather than a stale requester
    always_comb begin
        w_ram_address = {ADDR_W{1'b0}};
        w_ram_data    = {DATA_W{1'b0}};
        w_ram_wren    = 1'b0;
        if (w_host_gnt) begin
            w_ram_address = bus.host_addr;
            w_ram_data    = bus.host_wdata;
            w_ram_wren    = bus.host_we;
        end else if (w_cpu_gnt) begin
            w_ram_address = bus.cpu_addr;
            w_ram_data    = bus.cpu_wdata;
            w_ram_wren    = bus.cpu_we;
        end else begin
            w_ram_address = {ADDR_W{1'b0}};
            w_ram_data    = {DATA_W{1'b0}};
            w_ram_wren    = 1'b0;
        end
    end

    // Remember who issued a read so the next-cycle RAM data returns to them
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid      <= 1'b0;
            r_rd_owner_host <= 1'b0;
        end else begin
            r_rd_valid      <= (w_host_gnt && !bus.host_we) || (w_cpu_gnt && !bus.cpu_we);
            r_rd_owner_host <= w_host_gnt;
        end
    end

    assign bus.cpu_stall     = bus.cpu_req && !w_cpu_gnt && !reset;
    assign bus.host_gnt      = w_host_gnt;
    assign bus.cpu_rvalid    = r_rd_valid && !r_rd_owner_host && !reset;
    assign bus.host_rvalid   = r_rd_valid && r_rd_owner_host && !reset;
    assign bus.cpu_rdata     = bus.ram_q;
    assign bus.host_rdata    = bus.ram_q;
    assign bus.host_lock_ack = (r_state == S_LOCK) && !reset;
    assign bus.ram_address   = w_ram_address;
    assign bus.ram_data      = w_ram_data;
    assign bus.ram_wren      = w_ram_wren;

endmodule
